// File: rtl/arith_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : arith_cmd_sequencer
// Description : Command FIFO plus issue/capture FSM in front of the
//               synchronous arithmetic unit, with a saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module arith_cmd_sequencer #(
    parameter int M     = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [M-1:0]     i_cmd_A,
    input  logic [M-1:0]     i_cmd_B,
    input  logic [3:0]       i_cmd_op,
    input  logic [TAG_W-1:0] i_cmd_tag,
    output logic [M-1:0]     o_arg_A,
    output logic [M-1:0]     o_arg_B,
    output logic [3:0]       o_op,
    input  logic [M-1:0]     i_unit_result,
    input  logic [3:0]       i_unit_status,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [M-1:0]     o_rsp_result,
    output logic [3:0]       o_rsp_status,
    output logic [TAG_W-1:0] o_rsp_tag,
    input  logic             i_clr_err,
    output logic [15:0]      o_err_count,
    output logic             o_busy
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [15:0]        c_ERR_MAX = 16'hFFFF;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;
    localparam logic [1:0] c_ST_HOLD    = 2'd3;

    logic [M-1:0]       r_mem_a   [DEPTH];
    logic [M-1:0]       r_mem_b   [DEPTH];
    logic [3:0]         r_mem_op  [DEPTH];
    logic [TAG_W-1:0]   r_mem_tag [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [1:0]         r_state;
    logic [M-1:0]       r_arg_a;
    logic [M-1:0]       r_arg_b;
    logic [3:0]         r_op;
    logic [TAG_W-1:0]   r_pend_tag;
    logic               r_rsp_valid;
    logic [M-1:0]       r_rsp_result;
    logic [3:0]         r_rsp_status;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic [15:0]        r_err_count;

    logic w_fifo_ne;
    logic w_push;
    logic w_pop;

    assign w_fifo_ne = (r_count != '0);
    assign w_push    = i_cmd_valid && (r_count != c_FULL);
    // A pop happens only when the FSM is free to start the next command.
    assign w_pop     = w_fifo_ne &&
                       ((r_state == c_ST_IDLE) || ((r_state == c_ST_HOLD) && i_rsp_ready));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]   <= i_cmd_A;
            r_mem_b[r_wr_ptr]   <= i_cmd_B;
            r_mem_op[r_wr_ptr]  <= i_cmd_op;
            r_mem_tag[r_wr_ptr] <= i_cmd_tag;
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= c_ST_IDLE;
            r_arg_a      <= '0;
            r_arg_b      <= '0;
            r_op         <= '0;
            r_pend_tag   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_status <= '0;
            r_rsp_tag    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_arg_a    <= r_mem_a[r_rd_ptr];
                        r_arg_b    <= r_mem_b[r_rd_ptr];
                        r_op       <= r_mem_op[r_rd_ptr];
                        r_pend_tag <= r_mem_tag[r_rd_ptr];
                        r_state    <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    r_state <= c_ST_CAPTURE;
                end
                c_ST_CAPTURE: begin
                    r_rsp_result <= i_unit_result;
                    r_rsp_status <= i_unit_status;
                    r_rsp_tag    <= r_pend_tag;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= c_ST_HOLD;
                end
                c_ST_HOLD: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (w_pop) begin
                            r_arg_a    <= r_mem_a[r_rd_ptr];
                            r_arg_b    <= r_mem_b[r_rd_ptr];
                            r_op       <= r_mem_op[r_rd_ptr];
                            r_pend_tag <= r_mem_tag[r_rd_ptr];
                            r_state    <= c_ST_ISSUE;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Clear has priority over an increment landing in the same cycle.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_err_count <= '0;
        end else if (i_clr_err) begin
            r_err_count <= '0;
        end else if ((r_state == c_ST_CAPTURE) && i_unit_status[3] &&
                     (r_err_count != c_ERR_MAX)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign o_cmd_ready  = (r_count != c_FULL);
    assign o_arg_A      = r_arg_a;
    assign o_arg_B      = r_arg_b;
    assign o_op         = r_op;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_status = r_rsp_status;
    assign o_rsp_tag    = r_rsp_tag;
    assign o_err_count  = r_err_count;
    assign o_busy       = w_fifo_ne || (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_arith_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_cmd_sequencer
// Description : Directed/random bench for arith_cmd_sequencer with a
//               transaction-level reference model and a simple unit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_cmd_sequencer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        cmd_valid;
    logic [31:0] cmd_a, cmd_b;
    logic [3:0]  cmd_op, cmd_tag;
    logic        rsp_ready, clr_err, preload;
    logic        o_cmd_ready, o_rsp_valid, o_busy;
    logic [31:0] o_arg_A, o_arg_B, o_rsp_result;
    logic [3:0]  o_op, o_rsp_status, o_rsp_tag;
    logic [15:0] o_err_count;
    logic [31:0] unit_result;
    logic [3:0]  unit_status;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arith_cmd_sequencer #(.M(32), .DEPTH(DEPTH), .TAG_W(4)) dut (
        .clk(clk), .i_reset(i_reset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_A(cmd_a), .i_cmd_B(cmd_b), .i_cmd_op(cmd_op), .i_cmd_tag(cmd_tag),
        .o_arg_A(o_arg_A), .o_arg_B(o_arg_B), .o_op(o_op),
        .i_unit_result(unit_result), .i_unit_status(unit_status),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_result(o_rsp_result), .o_rsp_status(o_rsp_status), .o_rsp_tag(o_rsp_tag),
        .i_clr_err(clr_err), .o_err_count(o_err_count), .o_busy(o_busy)
    );

    // Arithmetic unit stand-in: {status, result}, status[3] = ERROR, status[0] = ZERO.
    function automatic logic [35:0] unit_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        logic [31:0] r;
        logic        err;
        r   = '0;
        err = 1'b0;
        case (op)
            4'd0: r = a >> b[4:0];
            4'd1: r = a + b;
            4'd2: if (b == 32'd0) err = 1'b1; else r = a / b;
            4'd3: r = a ^ b;
            4'd4: r = a - b;
            default: err = 1'b1;
        endcase
        return {err, 2'b00, (r == 32'd0), r};
    endfunction

    always @(posedge clk) {unit_status, unit_result} <= unit_fn(o_arg_A, o_arg_B, o_op);

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [3:0]  tag;
    } cmd_t;

    cmd_t        m_q[$];
    cmd_t        m_cur, m_new;
    bit          m_inflight, m_valid, m_cap, m_rdy;
    int          m_age;
    logic [31:0] m_res, m_a, m_b;
    logic [3:0]  m_stat, m_tag, m_op;
    logic [15:0] m_err;

    // Transaction model: one command in flight, response 2 edges after its pop.
    always @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            m_q.delete();
            m_inflight = 0; m_valid = 0; m_age = 0;
            m_res = '0; m_stat = '0; m_tag = '0; m_err = '0;
            m_a = '0; m_b = '0; m_op = '0;
        end else begin
            m_rdy = (m_q.size() < DEPTH);
            m_cap = 0;
            if (m_valid && rsp_ready) m_valid = 0;
            if (m_inflight) begin
                if (m_age == 1) begin
                    {m_stat, m_res} = unit_fn(m_cur.a, m_cur.b, m_cur.op);
                    m_tag = m_cur.tag;
                    m_valid = 1; m_inflight = 0; m_cap = 1;
                end else begin
                    m_age++;
                end
            end else if (!m_valid && m_q.size() != 0) begin
                m_cur = m_q.pop_front();
                m_a = m_cur.a; m_b = m_cur.b; m_op = m_cur.op;
                m_inflight = 1; m_age = 0;
            end
            if (cmd_valid && m_rdy) begin
                m_new.a = cmd_a; m_new.b = cmd_b; m_new.op = cmd_op; m_new.tag = cmd_tag;
                m_q.push_back(m_new);
            end
            if (clr_err) m_err = '0;
            else if (preload) m_err = 16'hFFFE;
            else if (m_cap && m_stat[3] && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s observed=no_event expected=event_within_bound", tag);
    endtask

    task automatic tick();
        @(negedge clk);
        chk("cmd_ready", 64'(o_cmd_ready), 64'(m_q.size() < DEPTH));
        chk("rsp_valid", 64'(o_rsp_valid), 64'(m_valid));
        chk("rsp_result", 64'(o_rsp_result), 64'(m_res));
        chk("rsp_status", 64'(o_rsp_status), 64'(m_stat));
        chk("rsp_tag", 64'(o_rsp_tag), 64'(m_tag));
        chk("err_count", 64'(o_err_count), 64'(m_err));
        chk("busy", 64'(o_busy), 64'((m_q.size() != 0) || m_inflight || m_valid));
        chk("arg_A", 64'(o_arg_A), 64'(m_a));
        chk("arg_B", 64'(o_arg_B), 64'(m_b));
        chk("op", 64'(o_op), 64'(m_op));
    endtask

    // Returns at the falling edge right after the accepting rising edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [3:0] tag);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
        while (!o_cmd_ready && n < 100) begin tick(); n++; end
        if (!o_cmd_ready) timeout("send");
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (o_busy && n < 100) begin tick(); n++; end
        if (o_busy) timeout("drain");
    endtask

    task automatic check_latency(input string tag, input logic [31:0] res,
                                 input logic [3:0] t);
        chk({tag, "_k0"}, 64'(o_rsp_valid), 64'(0));
        tick();
        chk({tag, "_k1"}, 64'(o_rsp_valid), 64'(0));
        tick();
        chk({tag, "_k2"}, 64'(o_rsp_valid), 64'(0));
        tick();
        chk({tag, "_k3_valid"}, 64'(o_rsp_valid), 64'(1));
        chk({tag, "_k3_result"}, 64'(o_rsp_result), 64'(res));
        chk({tag, "_k3_err"}, 64'(o_rsp_status[3]), 64'(0));
        chk({tag, "_k3_tag"}, 64'(o_rsp_tag), 64'(t));
    endtask

    initial begin
        int acc, hs, n;
        i_reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        rsp_ready = 1'b0; clr_err = 1'b0; preload = 1'b0;
        repeat (2) tick();
        chk("rst_cmd_ready", 64'(o_cmd_ready), 64'(1));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_err", 64'(o_err_count), 64'(0));
        i_reset = 1'b0;
        tick();

        // Single command latency
        rsp_ready = 1'b1;
        send(32'h80, 32'd3, 4'd0, 4'd5);
        check_latency("single", 32'h10, 4'd5);
        drain();

        // Backpressure fill, then drain with random stalls
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = 1'b1; cmd_a = $urandom; cmd_b = $urandom;
            cmd_op = 4'($urandom_range(0, 4)); cmd_tag = 4'(acc);
            if (o_cmd_ready) acc++;
            tick();
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'(5));
        chk("bp_ready_low", 64'(o_cmd_ready), 64'(0));
        repeat (4) tick();
        hs = 0; n = 0;
        while (hs < 5 && n < 200) begin
            rsp_ready = 1'($urandom % 2);
            if (o_rsp_valid && rsp_ready) begin
                chk("bp_order_tag", 64'(o_rsp_tag), 64'(hs));
                hs++;
            end
            tick();
            n++;
        end
        if (hs < 5) timeout("bp_drain");
        drain();

        // Push coincident with the HOLD->ISSUE pop at count 3
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send($urandom, $urandom, 4'd1, 4'(8 + i));
        n = 0;
        while (!o_rsp_valid && n < 20) begin tick(); n++; end
        if (!o_rsp_valid) timeout("pp_wait_valid");
        chk("pp_ready_before", 64'(o_cmd_ready), 64'(1));
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_a = $urandom; cmd_b = $urandom; cmd_op = 4'd3; cmd_tag = 4'd12;
        tick();
        rsp_ready = 1'b0;
        chk("pp_ready_kept", 64'(o_cmd_ready), 64'(1));
        cmd_tag = 4'd13;
        tick();
        cmd_valid = 1'b0;
        chk("pp_full_after_push", 64'(o_cmd_ready), 64'(0));
        drain();

        // Error path and clear-wins
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        rsp_ready = 1'b1;
        send($urandom, $urandom, 4'b0111, 4'd1);
        send($urandom, 32'd0, 4'd2, 4'd2);
        drain();
        chk("err_count_two", 64'(o_err_count), 64'(2));
        send($urandom, $urandom, 4'b0111, 4'd3);
        tick();
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_wins", 64'(o_err_count), 64'(0));
        chk("clr_rsp_err", 64'(o_rsp_status[3]), 64'(1));
        drain();

        // Saturation from a preloaded count
        preload = 1'b1;
        force dut.r_err_count = 16'hFFFE;
        tick();
        preload = 1'b0;
        release dut.r_err_count;
        send($urandom, $urandom, 4'd9, 4'd4);
        drain();
        chk("sat_first", 64'(o_err_count), 64'(16'hFFFF));
        send($urandom, $urandom, 4'd15, 4'd5);
        send($urandom, 32'd0, 4'd2, 4'd6);
        drain();
        chk("sat_hold", 64'(o_err_count), 64'(16'hFFFF));

        // Random traffic
        for (int i = 0; i < 120; i++) begin
            cmd_valid = 1'($urandom % 2); cmd_a = $urandom; cmd_b = $urandom;
            cmd_op = 4'($urandom_range(0, 7)); cmd_tag = 4'($urandom);
            rsp_ready = 1'(($urandom % 4) != 0);
            clr_err = 1'(($urandom % 16) == 0);
            tick();
        end
        cmd_valid = 1'b0; clr_err = 1'b0;
        drain();

        // Reset during CAPTURE with two commands queued
        rsp_ready = 1'b0;
        send($urandom, $urandom, 4'd1, 4'd1);
        send($urandom, $urandom, 4'd1, 4'd2);
        send($urandom, $urandom, 4'd1, 4'd3);
        #2 i_reset = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", 64'(o_cmd_ready), 64'(1));
        chk("mid_rst_arg_A", 64'(o_arg_A), 64'(0));
        chk("mid_rst_arg_B", 64'(o_arg_B), 64'(0));
        chk("mid_rst_op", 64'(o_op), 64'(0));
        chk("mid_rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
        chk("mid_rst_rsp_result", 64'(o_rsp_result), 64'(0));
        chk("mid_rst_rsp_status", 64'(o_rsp_status), 64'(0));
        chk("mid_rst_rsp_tag", 64'(o_rsp_tag), 64'(0));
        chk("mid_rst_err", 64'(o_err_count), 64'(0));
        chk("mid_rst_busy", 64'(o_busy), 64'(0));
        tick();
        i_reset = 1'b0;
        repeat (6) tick();
        rsp_ready = 1'b1;
        send(32'h80, 32'd3, 4'd0, 4'd6);
        check_latency("post_rst", 32'h10, 4'd6);
        drain();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arith_cmd_sequencer.md
# arith_cmd_sequencer

Command front-end for the synchronous arithmetic unit. It buffers operand/opcode commands in a small FIFO and issues them one at a time to the unit's `iarg_A`/`iarg_B`/`iop` inputs. It captures the unit's registered `o_result`/`o_status` one cycle after issue and returns them, with the command's tag, over a valid/ready response port. It also keeps a saturating count of commands the unit flagged as errors.

## Interface
Parameters:
- `M`, 32: operand/result width; must match the unit's `M`.
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TAG_W`, 4: width of the command tag.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `i_reset`, in, 1: reset, asynchronous, active-high.
- `i_cmd_valid`, in, 1: command present.
- `o_cmd_ready`, out, 1: FIFO can accept a command.
- `i_cmd_A`, in, M: operand A.
- `i_cmd_B`, in, M: operand B.
- `i_cmd_op`, in, 4: opcode.
- `i_cmd_tag`, in, TAG_W: tag, returned unchanged with the response.
- `o_arg_A`, out, M: to unit `iarg_A`.
- `o_arg_B`, out, M: to unit `iarg_B`.
- `o_op`, out, 4: to unit `iop`.
- `i_unit_result`, in, M: from unit `o_result`.
- `i_unit_status`, in, 4: from unit `o_status`; bit 3 = ERROR.
- `o_rsp_valid`, out, 1: response present.
- `i_rsp_ready`, in, 1: consumer accepts the response.
- `o_rsp_result`, out, M: captured result.
- `o_rsp_status`, out, 4: captured status.
- `o_rsp_tag`, out, TAG_W: tag of the command that produced the response.
- `i_clr_err`, in, 1: synchronous clear of the error counter.
- `o_err_count`, out, 16: number of responses with ERROR set; saturating.
- `o_busy`, out, 1: high when the FIFO is non-empty or the FSM is not in IDLE.

## Operation
- **FIFO**
  - Holds DEPTH entries of {A, B, op, tag}, with a count register in the range 0..DEPTH.
  - Read and write pointers wrap modulo DEPTH.
  - `o_cmd_ready` = (count < DEPTH), decoded from registered count only; a same-cycle pop never raises it.
  - Push when `i_cmd_valid && o_cmd_ready`.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - There is no bypass: a command spends at least one cycle in the FIFO.
- **FSM states:** IDLE, ISSUE, CAPTURE, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head into the `o_arg_A/o_arg_B/o_op` registers and a pending-tag register, then go to ISSUE; otherwise stay.
  - ISSUE: arguments are stable at the unit inputs and the unit registers them at the end of this cycle. Go to CAPTURE unconditionally.
  - CAPTURE: latch `i_unit_result`, `i_unit_status` and the pending tag into the `o_rsp_*` registers. Set `o_rsp_valid`. If `i_unit_status[3]`, increment the error counter. Go to HOLD.
  - HOLD: hold `o_rsp_*` stable while `!i_rsp_ready`. When `i_rsp_ready`, clear `o_rsp_valid`. In that same cycle, if the FIFO is non-empty, pop the next command and go to ISSUE; otherwise go to IDLE.
- `o_arg_*`/`o_op` keep their last issued values until the next pop.
- **Error counter**
  - Saturates at 16'hFFFF.
  - `i_clr_err` wins over a simultaneous increment: the result is 0.
- Responses are returned strictly in command order; only one command is in flight.
- **Reset (any time, including mid-operation)**
  - Behaviour: FIFO emptied, pointers and count 0, FSM to IDLE, any in-flight command and pending response discarded.
  - Values: `o_cmd_ready`=1, `o_arg_A`=`o_arg_B`=0, `o_op`=0, `o_rsp_valid`=0, `o_rsp_result`=0, `o_rsp_status`=0, `o_rsp_tag`=0, `o_err_count`=0, `o_busy`=0.

## Timing
- Command accepted at edge k → popped at edge k+1 → unit samples at edge k+2 → response captured at edge k+3. `o_rsp_valid` is high from edge k+3, a latency of 3 cycles.
- With `i_rsp_ready` held at 1, back-to-back throughput is one response per 3 cycles (HOLD → ISSUE → CAPTURE → HOLD).
- `o_rsp_*` must not change while `o_rsp_valid && !i_rsp_ready`.
- All outputs are registered; there is no combinational path from an input to an output.

## Test plan
- **Single command:** A=32'h80, B=3, op=0, tag=5 → `o_rsp_valid` rises at the 3rd edge after accept, with result 32'h10, status[3]=0, tag 5.
- **Backpressure fill:** `i_rsp_ready`=0, commands offered on every cycle → exactly 5 accepted (1 in flight + 4 queued), `o_cmd_ready` low after the 5th. Then raise `i_rsp_ready` → 5 responses with tags 0..4 in order, each stable while stalled.
- **Error path:** op=4'b0111, then op=2 with B=0 → both responses have status[3]=1 and `o_err_count`=2. Then pulse `i_clr_err` together with a third error capture → count reads 0.
- **Saturation:** preload the counter to 16'hFFFE via 2 forced errors in a shortened bench (or force), then 3 more errors → count stays at 16'hFFFF.
- **Simultaneous push/pop at count 3:** push on the same cycle as the HOLD→ISSUE pop → count stays 3 and `o_cmd_ready` stays 1.
- **Reset mid-operation:** assert `i_reset` during CAPTURE with 2 commands queued → all outputs reach their reset values immediately. After release, the next command sees 3-cycle latency and no stale responses appear.
